// File: rtl/apb_reg_slave_if.sv
// APB4 bus bundle between a requester and apb_reg_slave.
// Widths are set per instance and must match the attached slave's parameters.
interface apb_reg_slave_if #(
  parameter int unsigned APB_DW = 32,
  parameter int unsigned APB_AW = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_AW-1:0]     paddr;
  logic [APB_DW-1:0]     pwdata;
  logic [APB_DW/8-1:0]   pstrb;
  logic [APB_DW-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_slave.sv
// APB4 completer with a DEPTH-word register bank, programmable wait states and pslverr.
// Optional macro APB_REG_SLAVE_PSTRB_EN enables per-byte write strobes (else full-word writes).
module apb_reg_slave #(
  parameter int unsigned APB_DW = 32,
  parameter int unsigned APB_AW = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WAIT_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  apb_reg_slave_if.slave    apb,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int unsigned NB    = APB_DW / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  // Transfer register captured in the setup cycle
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              write;
    logic              err;
    logic [APB_DW-1:0] wdata;
`ifdef APB_REG_SLAVE_PSTRB_EN
    logic [NB-1:0]     strb;
`endif
  } xfer_t;

  state_t              r_state;
  xfer_t               r_x;
  logic [WAIT_W-1:0]   r_wcnt;
  logic                r_pready;
  logic                r_pslverr;
  logic [APB_DW-1:0]   r_prdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [APB_DW-1:0]   r_mem [DEPTH];

  logic                w_setup;
  logic                w_access;
  logic                w_err;
  logic [IDX_W-1:0]    w_idx;
  logic [APB_DW-1:0]   w_wmask;

  assign w_setup  = apb.psel & ~apb.penable;
  assign w_access = apb.psel &  apb.penable;
  assign w_idx    = IDX_W'(apb.paddr >> LSB);
  // Out-of-range word index or misaligned byte address
  assign w_err    = ((apb.paddr >> LSB) >= APB_AW'(DEPTH)) ||
                    ((apb.paddr & APB_AW'(NB - 1)) != '0);

  always_comb begin
    w_wmask = '1;
`ifdef APB_REG_SLAVE_PSTRB_EN
    for (int b = 0; b < int'(NB); b++) begin
      w_wmask[b*8 +: 8] = {8{r_x.strb[b]}};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_wcnt    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_state     <= S_ACCESS;
            r_wcnt      <= wait_cfg;
            r_x.idx     <= w_idx;
            r_x.write   <= apb.pwrite;
            r_x.err     <= w_err;
            r_x.wdata   <= apb.pwdata;
`ifdef APB_REG_SLAVE_PSTRB_EN
            r_x.strb    <= apb.pstrb;
`endif
            // Zero wait states: the first access cycle already completes
            if (wait_cfg == '0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= (!apb.pwrite && !w_err) ? r_mem[w_idx] : '0;
            end
          end
        end
        S_ACCESS: begin
          if (!w_access) begin
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
          end else if (r_pready) begin
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_cnt     <= r_cnt + CNT_W'(1);
            if (r_x.write && !r_x.err) begin
              r_mem[r_x.idx] <= (r_mem[r_x.idx] & ~w_wmask) | (r_x.wdata & w_wmask);
            end
          end else begin
            r_wcnt <= r_wcnt - WAIT_W'(1);
            if (r_wcnt == WAIT_W'(1)) begin
              r_pready  <= 1'b1;
              r_pslverr <= r_x.err;
              r_prdata  <= (!r_x.write && !r_x.err) ? r_mem[r_x.idx] : '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;
  assign apb.prdata  = r_prdata;
  assign xfer_cnt    = r_cnt;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed self-checking bench for apb_reg_slave (32-bit data, DEPTH=16, CNT_W=4).
module tb_apb_reg_slave;

  logic       clk;
  logic       reset_n;
  logic [3:0] wait_cfg;
  logic [3:0] xfer_cnt;

  int         n_tests;
  int         n_fail;
  logic [3:0] exp_cnt;

  apb_reg_slave_if #(.APB_DW(32), .APB_AW(32)) u_if ();

  apb_reg_slave #(
    .APB_DW(32), .APB_AW(32), .DEPTH(16), .WAIT_W(4), .CNT_W(4)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .apb      (u_if),
    .wait_cfg (wait_cfg),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Setup + access phases; returns at the negedge where pready is seen, bus left in access
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int n,
                          output logic [31:0] rd, output logic err);
    int cyc;
    @(negedge clk);
    chk_eq("pready_low_before_setup", 64'(u_if.pready), 64'd0);
    u_if.psel    = 1'b1;
    u_if.penable = 1'b0;
    u_if.pwrite  = wr;
    u_if.paddr   = addr;
    u_if.pwdata  = wdata;
    u_if.pstrb   = strb;
    wait_cfg     = 4'(n);
    @(negedge clk);
    u_if.penable = 1'b1;
    wait_cfg     = 4'hF;
    cyc = 1;
    while (u_if.pready !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq("access_cycles", 64'(cyc), 64'(n + 1));
    rd  = u_if.prdata;
    err = u_if.pslverr;
    exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int n, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, a, d, s, n, rd, err);
    chk_eq("wr_pslverr", 64'(err), 64'(exp_err));
  endtask

  task automatic do_rd(input string tag, input logic [31:0] a, input int n,
                       input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b0, a, 32'h0, 4'h0, n, rd, err);
    chk_eq({tag, "_data"}, 64'(rd), 64'(exp_d));
    chk_eq({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic bus_idle();
    @(negedge clk);
    u_if.psel    = 1'b0;
    u_if.penable = 1'b0;
    chk_eq("pready_one_cycle", 64'(u_if.pready), 64'd0);
    chk_eq("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
  endtask

  initial begin
    logic [31:0] exp_strb;
    logic [31:0] exp_zero_strb;
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 4'd0;
    reset_n = 1'b0;
    wait_cfg = 4'd0;
    u_if.psel = 1'b0; u_if.penable = 1'b0; u_if.pwrite = 1'b0;
    u_if.paddr = '0; u_if.pwdata = '0; u_if.pstrb = '0;

    repeat (2) @(negedge clk);
    chk_eq("rst_pready",  64'(u_if.pready),  64'd0);
    chk_eq("rst_pslverr", 64'(u_if.pslverr), 64'd0);
    chk_eq("rst_prdata",  64'(u_if.prdata),  64'd0);
    chk_eq("rst_cnt",     64'(xfer_cnt),     64'd0);
    reset_n = 1'b1;

    // All words read zero after reset, two cycles each, back-to-back
    for (int i = 0; i < 16; i++) do_rd("rst_word", 32'(i * 4), 0, 32'h0, 1'b0);
    bus_idle();

    // Write then immediate read with three wait states
    do_wr(32'h08, 32'hA5A5_5A5A, 4'hF, 0, 1'b0);
    do_rd("raw_wait3", 32'h08, 3, 32'hA5A5_5A5A, 1'b0);
    bus_idle();

    // Byte strobes
`ifdef APB_REG_SLAVE_PSTRB_EN
    exp_strb      = 32'h11FF_33FF;
    exp_zero_strb = 32'h0;
`else
    exp_strb      = 32'hFFFF_FFFF;
    exp_zero_strb = 32'h1234_5678;
`endif
    do_wr(32'h04, 32'h1122_3344, 4'hF, 1, 1'b0);
    do_wr(32'h04, 32'hFFFF_FFFF, 4'b0101, 2, 1'b0);
    do_rd("strb_0101", 32'h04, 1, exp_strb, 1'b0);
    do_wr(32'h0C, 32'h1234_5678, 4'h0, 0, 1'b0);
    do_rd("strb_none", 32'h0C, 0, exp_zero_strb, 1'b0);
    bus_idle();

    // Error cases: out of range, misaligned; bank untouched
    do_wr(32'h40, 32'hDEAD_0BAD, 4'hF, 0, 1'b1);
    do_rd("err_misalign", 32'h02, 0, 32'h0, 1'b1);
    do_rd("err_range", 32'h40, 2, 32'h0, 1'b1);
    do_rd("alias_word0", 32'h00, 0, 32'h0, 1'b0);
    do_wr(32'h3C, 32'hBEEF_0015, 4'hF, 0, 1'b0);
    do_rd("last_word", 32'h3C, 1, 32'hBEEF_0015, 1'b0);
    do_rd("still_a5", 32'h08, 0, 32'hA5A5_5A5A, 1'b0);
    bus_idle();

    // Abort: penable dropped in the second access cycle with wait_cfg=2
    do_wr(32'h14, 32'hCAFE_0005, 4'hF, 0, 1'b0);
    bus_idle();
    @(negedge clk);
    u_if.psel = 1'b1; u_if.penable = 1'b0; u_if.pwrite = 1'b1;
    u_if.paddr = 32'h14; u_if.pwdata = 32'hDEAD_BEEF; u_if.pstrb = 4'hF; wait_cfg = 4'd2;
    @(negedge clk);
    u_if.penable = 1'b1;
    chk_eq("abort_acc1_pready", 64'(u_if.pready), 64'd0);
    @(negedge clk);
    chk_eq("abort_acc2_pready", 64'(u_if.pready), 64'd0);
    u_if.penable = 1'b0;
    @(negedge clk);
    u_if.psel = 1'b0;
    chk_eq("abort_pready", 64'(u_if.pready), 64'd0);
    chk_eq("abort_cnt", 64'(xfer_cnt), 64'(exp_cnt));
    repeat (2) @(negedge clk);
    chk_eq("abort_no_late_pready", 64'(u_if.pready), 64'd0);
    do_rd("abort_no_write", 32'h14, 0, 32'hCAFE_0005, 1'b0);
    bus_idle();

    // Asynchronous reset while a read is presenting data
    do_wr(32'h18, 32'h55AA_55AA, 4'hF, 0, 1'b0);
    bus_idle();
    @(negedge clk);
    u_if.psel = 1'b1; u_if.penable = 1'b0; u_if.pwrite = 1'b0;
    u_if.paddr = 32'h18; wait_cfg = 4'd0;
    @(negedge clk);
    u_if.penable = 1'b1;
    chk_eq("pre_rst_pready", 64'(u_if.pready), 64'd1);
    chk_eq("pre_rst_prdata", 64'(u_if.prdata), 64'h55AA_55AA);
    #1 reset_n = 1'b0;
    #1;
    chk_eq("async_rst_pready", 64'(u_if.pready), 64'd0);
    chk_eq("async_rst_prdata", 64'(u_if.prdata), 64'd0);
    chk_eq("async_rst_cnt",    64'(xfer_cnt),    64'd0);
    u_if.psel = 1'b0; u_if.penable = 1'b0;
    exp_cnt = 4'd0;
    @(negedge clk);
    reset_n = 1'b1;

    // Seventeen transfers wrap the 4-bit counter to 1
    do_rd("post_rst_word6", 32'h18, 0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_wr(32'(i * 4), 32'(32'h100 + i), 4'hF, i % 3, 1'b0);
      do_rd("wrap_rd", 32'(i * 4), 0, 32'(32'h100 + i), 1'b0);
    end
    bus_idle();
    chk_eq("cnt_wrap_17", 64'(xfer_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
